// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int          INST_WIDTH = 32;
    localparam int          ADDR_WIDTH = 32;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    // Refill controller states
    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Tag width left over once byte, offset and index bits are removed
    function automatic int tag_bits(input int index_bits, input int offset_bits);
        return ADDR_WIDTH - 2 - offset_bits - index_bits;
    endfunction

    // Lowest address bit that belongs to the line (index) field
    function automatic int line_lsb(input int offset_bits);
        return offset_bits + 2;
    endfunction

endpackage

// File: rtl/inst_cache_line_store.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port, one write port with a set-valid strobe, and a flush-all strobe.
module inst_cache_line_store
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_all_i,
    input  logic [INDEX_BITS-1:0]  rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    output logic                   rd_valid_o,
    output logic [TAG_BITS-1:0]    rd_tag_o,
    output logic [INST_WIDTH-1:0]  rd_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_BITS-1:0]  wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [INST_WIDTH-1:0]  wr_data_i,
    input  logic                   set_valid_i,
    input  logic [TAG_BITS-1:0]    set_tag_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [INST_WIDTH-1:0] data_q [LINES*WORDS];

    // Valid bits: cleared by reset and flush; flush wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_all_i) begin
            valid_q <= '0;
        end else if (set_valid_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Tag array: written when a line completes its refill (not reset)
    always_ff @(posedge clk) begin
        if (set_valid_i) begin
            tag_q[wr_index_i] <= set_tag_i;
        end
    end

    // Data array: one word per refill beat (not reset)
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with a zero-latency hit path
// and a two-state refill controller that fetches a whole line on a miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] ins_address,
    input  logic                  flush,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  hit,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
    localparam int LINE_LSB = line_lsb(OFFSET_BITS);
    localparam int TAG_LSB  = LINE_LSB + INDEX_BITS;

    localparam logic [ADDR_WIDTH-1:0]  LINE_MASK = ~((32'd1 << LINE_LSB) - 32'd1);
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = '1;
    localparam logic [OFFSET_BITS-1:0] BEAT_ONE  = OFFSET_BITS'(1);

    state_e                  state_q, state_d;
    logic [OFFSET_BITS-1:0]  counter_q, counter_d;
    logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
    logic                    pend_flush_q, pend_flush_d;

    logic [OFFSET_BITS-1:0]  lu_offset_s;
    logic [INDEX_BITS-1:0]   lu_index_s;
    logic [TAG_BITS-1:0]     lu_tag_s;
    logic                    rd_valid_s;
    logic [TAG_BITS-1:0]     rd_tag_s;
    logic [INST_WIDTH-1:0]   rd_data_s;
    logic                    lookup_hit_s;

    logic                    wr_en_s;
    logic                    set_valid_s;
    logic                    flush_all_s;
    logic [INDEX_BITS-1:0]   fill_index_s;
    logic [TAG_BITS-1:0]     fill_tag_s;

    assign lu_offset_s  = ins_address[LINE_LSB-1:2];
    assign lu_index_s   = ins_address[TAG_LSB-1:LINE_LSB];
    assign lu_tag_s     = ins_address[ADDR_WIDTH-1:TAG_LSB];
    assign fill_index_s = line_addr_q[TAG_LSB-1:LINE_LSB];
    assign fill_tag_s   = line_addr_q[ADDR_WIDTH-1:TAG_LSB];

    inst_cache_line_store #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_all_i (flush_all_s),
        .rd_index_i  (lu_index_s),
        .rd_offset_i (lu_offset_s),
        .rd_valid_o  (rd_valid_s),
        .rd_tag_o    (rd_tag_s),
        .rd_data_o   (rd_data_s),
        .wr_en_i     (wr_en_s),
        .wr_index_i  (fill_index_s),
        .wr_offset_i (counter_q),
        .wr_data_i   (mem_rdata),
        .set_valid_i (set_valid_s),
        .set_tag_i   (fill_tag_s)
    );

    // Lookup and memory-side outputs; lookups only hit while IDLE
    always_comb begin
        lookup_hit_s = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        if (state_q == IDLE) begin
            lookup_hit_s = fetch_valid & rd_valid_s & (rd_tag_s == lu_tag_s);
        end else begin
            mem_req  = 1'b1;
            mem_addr = line_addr_q
                     + {{(ADDR_WIDTH-OFFSET_BITS-2){1'b0}}, counter_q, 2'b00};
        end
        hit         = lookup_hit_s;
        instruction = lookup_hit_s ? rd_data_s : NOP;
    end

    // Next-state logic: miss detection, beat counting, flush tracking
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        line_addr_d  = line_addr_q;
        pend_flush_d = pend_flush_q;
        wr_en_s      = 1'b0;
        set_valid_s  = 1'b0;
        flush_all_s  = flush;
        case (state_q)
            IDLE: begin
                pend_flush_d = 1'b0;
                if (fetch_valid && !lookup_hit_s) begin
                    state_d     = REFILL;
                    line_addr_d = ins_address & LINE_MASK;
                    counter_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                if (flush) begin
                    pend_flush_d = 1'b1;
                end else begin
                    pend_flush_d = pend_flush_q;
                end
                if (mem_rvalid) begin
                    wr_en_s   = 1'b1;
                    counter_d = counter_q + BEAT_ONE;
                    if (counter_q == LAST_BEAT) begin
                        // A flush seen at any point of this refill keeps the line invalid
                        set_valid_s  = !(pend_flush_q || flush);
                        pend_flush_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = REFILL;
                end
            end
            default: begin
                state_d      = IDLE;
                counter_d    = '0;
                pend_flush_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            line_addr_q  <= '0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            line_addr_q  <= line_addr_d;
            pend_flush_q <= pend_flush_d;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: table-driven fetch vectors plus
// hand-written refill corner cases, with a queue of expected beat addresses.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] ins_address;
    logic        flush;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    inst_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .ins_address (ins_address),
        .flush       (flush),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid)
    );

    // Instruction memory contents: 0x40..0x4C hold 0xAAAA0000..0xAAAA0003
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA_0000 + ((a - 32'h0000_0040) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One lookup cycle; a miss leaves the DUT in its first refill cycle
    task automatic fetch(input logic [31:0] addr, input logic fl,
                         input logic exp_hit, input logic [31:0] exp_instr);
        fetch_valid = 1'b1;
        ins_address = addr;
        flush       = fl;
        #1;
        chk("fetch_hit", {31'd0, hit}, {31'd0, exp_hit});
        chk("fetch_instr", instruction, exp_instr);
        chk("fetch_req", {31'd0, mem_req}, 32'd0);
        tick();
        flush = 1'b0;
    endtask

    // Serve a line refill with one idle cycle before every beat
    task automatic refill(input logic [31:0] line, input int flush_at, input int reset_at,
                          input logic alt_en, input logic [31:0] alt_addr);
        logic [31:0] exp;
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(line + 32'(4 * k));
        if (alt_en) begin
            fetch_valid = 1'b1;
            ins_address = alt_addr;
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("gap_req", {31'd0, mem_req}, 32'd1);
            chk("gap_hit", {31'd0, hit}, 32'd0);
            chk("gap_addr", mem_addr, exp_addr_q[0]);
            tick();
            exp        = exp_addr_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(exp);
            flush      = (k == flush_at);
            rst_n      = (k == reset_at) ? 1'b0 : 1'b1;
            #1;
            chk("beat_addr", mem_addr, exp);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            flush      = 1'b0;
            if (k == reset_at) begin
                rst_n = 1'b1;
                #1;
                chk("rst_req", {31'd0, mem_req}, 32'd0);
                chk("rst_hit", {31'd0, hit}, 32'd0);
                chk("rst_addr", mem_addr, 32'd0);
                exp_addr_q.delete();
                return;
            end
        end
        #1;
        chk("done_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0040, 1'b0, 32'h0000_0000};
        vecs[1] = '{32'h0000_0048, 1'b1, 32'hAAAA_0002};
        vecs[2] = '{32'h0000_0040, 1'b1, 32'hAAAA_0000};
        vecs[3] = '{32'h0000_0044, 1'b1, 32'hAAAA_0001};
        vecs[4] = '{32'h0000_004C, 1'b1, 32'hAAAA_0003};
        vecs[5] = '{32'h0000_0140, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'h0000_0148, 1'b1, 32'hAAAA_0042};
        vecs[7] = '{32'h0000_0040, 1'b0, 32'h0000_0000};
        vecs[8] = '{32'h0000_0044, 1'b1, 32'hAAAA_0001};

        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        ins_address = 32'h0;
        flush       = 1'b0;
        mem_rdata   = 32'h0;
        mem_rvalid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset_hit", {31'd0, hit}, 32'd0);
        chk("reset_instr", instruction, 32'd0);
        chk("reset_req", {31'd0, mem_req}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);

        // Basic miss/refill, sequential hits, and aliasing lines
        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i].addr, 1'b0, vecs[i].exp_hit, vecs[i].exp_instr);
            if (!vecs[i].exp_hit) refill(vecs[i].addr & 32'hFFFF_FFF0, -1, -1, 1'b0, 32'h0);
        end

        // Flush on the second beat: refill finishes but the line stays invalid
        fetch(32'h80, 1'b0, 1'b0, 32'h0);
        refill(32'h80, 1, -1, 1'b0, 32'h0);
        fetch(32'h80, 1'b0, 1'b0, 32'h0);
        refill(32'h80, -1, -1, 1'b0, 32'h0);
        fetch(32'h84, 1'b0, 1'b1, 32'hAAAA_0011);

        // Flush also cleared 0x40; address moves to 0x200 during its refill
        fetch(32'h44, 1'b0, 1'b0, 32'h0);
        refill(32'h40, -1, -1, 1'b1, 32'h200);
        fetch(32'h44, 1'b0, 1'b1, 32'hAAAA_0001);
        fetch(32'h200, 1'b0, 1'b0, 32'h0);
        // Fetch of a valid line during refill must not hit
        refill(32'h200, -1, -1, 1'b1, 32'h84);
        fetch(32'h208, 1'b0, 1'b1, 32'hAAAA_0072);

        // Flush in IDLE: same-cycle lookup sees the old state
        fetch(32'h84, 1'b1, 1'b1, 32'hAAAA_0011);
        fetch(32'h84, 1'b0, 1'b0, 32'h0);
        refill(32'h80, -1, -1, 1'b0, 32'h0);
        fetch(32'h8C, 1'b0, 1'b1, 32'hAAAA_0013);

        // Stray rvalid in IDLE must not write the arrays
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        fetch(32'h88, 1'b0, 1'b1, 32'hAAAA_0012);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        fetch(32'h88, 1'b0, 1'b1, 32'hAAAA_0012);
        fetch(32'h80, 1'b0, 1'b1, 32'hAAAA_0010);

        // Reset during beat 2 abandons the refill; re-fetch restarts at beat 0
        fetch(32'h300, 1'b0, 1'b0, 32'h0);
        refill(32'h300, -1, 2, 1'b0, 32'h0);
        fetch(32'h300, 1'b0, 1'b0, 32'h0);
        refill(32'h300, -1, -1, 1'b0, 32'h0);
        fetch(32'h30C, 1'b0, 1'b1, 32'hAAAA_00B3);
        fetch(32'h84, 1'b0, 1'b0, 32'h0);
        refill(32'h80, -1, -1, 1'b0, 32'h0);

        fetch_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
